// File: rtl/wisc_pkg.sv
// Shared ALU/decode/EX-stage definitions: op codes, branch conditions, widths.
package wisc_pkg;

  localparam int unsigned DW     = 16;
  localparam int unsigned RW     = 4;
  localparam int unsigned ALU_CW = 4;
  localparam int unsigned BR_CW  = 3;

  // ALU control codes, identical to the encoding the ALU consumes
  localparam logic [ALU_CW-1:0] ALU_ADD  = 4'b0000;
  localparam logic [ALU_CW-1:0] ALU_SUB  = 4'b0001;
  localparam logic [ALU_CW-1:0] ALU_NAND = 4'b0100;
  localparam logic [ALU_CW-1:0] ALU_XOR  = 4'b1000;
  localparam logic [ALU_CW-1:0] ALU_SLL  = 4'b1001;
  localparam logic [ALU_CW-1:0] ALU_SRL  = 4'b1010;
  localparam logic [ALU_CW-1:0] ALU_SRA  = 4'b1011;
  localparam logic [ALU_CW-1:0] ALU_LHB  = 4'b1100;
  localparam logic [ALU_CW-1:0] ALU_LLB  = 4'b1101;

  // Branch condition codes from decode
  localparam logic [BR_CW-1:0] BR_NE = 3'b000;
  localparam logic [BR_CW-1:0] BR_EQ = 3'b001;
  localparam logic [BR_CW-1:0] BR_GT = 3'b010;
  localparam logic [BR_CW-1:0] BR_LT = 3'b011;
  localparam logic [BR_CW-1:0] BR_GE = 3'b100;
  localparam logic [BR_CW-1:0] BR_LE = 3'b101;
  localparam logic [BR_CW-1:0] BR_OV = 3'b110;
  localparam logic [BR_CW-1:0] BR_UN = 3'b111;

  // Z/N/V triple, used both for flag values and for update masks
  typedef struct packed {
    logic z;
    logic n;
    logic v;
  } flags_t;

endpackage

// File: rtl/flag_mask_dec.sv
// Maps an ALU control code to the set of flags that op is allowed to update.
module flag_mask_dec
  import wisc_pkg::*;
(
  input  logic [ALU_CW-1:0] alu_ctrl,
  output flags_t            upd_c
);

  // Single home of the per-op flag-update table
  always_comb begin
    upd_c = '0;
    case (alu_ctrl)
      ALU_ADD, ALU_SUB: upd_c = '{z: 1'b1, n: 1'b1, v: 1'b1};
      ALU_NAND, ALU_XOR, ALU_SLL, ALU_SRL, ALU_SRA:
                        upd_c = '{z: 1'b1, n: 1'b0, v: 1'b0};
      default:          upd_c = '0;
    endcase
  end

endmodule

// File: rtl/ex_flag_stage.sv
// EX/MEM pipeline register with the architectural Z/N/V flags and branch evaluation.
module ex_flag_stage
  import wisc_pkg::*;
#(
  parameter int unsigned DW = wisc_pkg::DW,
  parameter int unsigned RW = wisc_pkg::RW
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ex_valid,
  input  logic [ALU_CW-1:0] ex_alu_ctrl,
  input  logic [DW-1:0]     ex_result,
  input  logic              ex_z,
  input  logic              ex_n,
  input  logic              ex_v,
  input  logic [RW-1:0]     ex_dst,
  input  logic              ex_wr_en,
  input  logic              stall,
  input  logic              flush,
  output logic              mem_valid,
  output logic [DW-1:0]     mem_result,
  output logic [RW-1:0]     mem_dst,
  output logic              mem_wr_en,
  output logic              flag_z,
  output logic              flag_n,
  output logic              flag_v,
  input  logic [BR_CW-1:0]  br_cond,
  output logic              br_taken
);

  flags_t upd_c;
  flags_t flags_q;

  flag_mask_dec u_flag_mask_dec (
    .alu_ctrl (ex_alu_ctrl),
    .upd_c    (upd_c)
  );

  // Pipeline register toward MEM; flush kills valid/write but keeps payload
  always_ff @(posedge clk) begin
    if (rst) begin
      mem_valid  <= 1'b0;
      mem_result <= '0;
      mem_dst    <= '0;
      mem_wr_en  <= 1'b0;
    end else if (flush) begin
      mem_valid  <= 1'b0;
      mem_wr_en  <= 1'b0;
    end else if (!stall) begin
      mem_valid  <= ex_valid;
      mem_result <= ex_result;
      mem_dst    <= ex_dst;
      mem_wr_en  <= ex_valid & ex_wr_en;
    end
  end

  // Committed flags: only a real, advancing instruction may touch them, masked per op
  always_ff @(posedge clk) begin
    if (rst) begin
      flags_q <= '0;
    end else if (!flush && !stall && ex_valid) begin
      if (upd_c.z) flags_q.z <= ex_z;
      if (upd_c.n) flags_q.n <= ex_n;
      if (upd_c.v) flags_q.v <= ex_v;
    end
  end

  assign flag_z = flags_q.z;
  assign flag_n = flags_q.n;
  assign flag_v = flags_q.v;

  // Branch decision from committed flags only; decode handles the flag hazard
  always_comb begin
    br_taken = 1'b0;
    case (br_cond)
      BR_NE:   br_taken = !flags_q.z;
      BR_EQ:   br_taken = flags_q.z;
      BR_GT:   br_taken = !flags_q.z && !flags_q.n;
      BR_LT:   br_taken = flags_q.n;
      BR_GE:   br_taken = flags_q.z || !flags_q.n;
      BR_LE:   br_taken = flags_q.z || flags_q.n;
      BR_OV:   br_taken = flags_q.v;
      BR_UN:   br_taken = 1'b1;
      default: br_taken = 1'b0;
    endcase
  end

endmodule

// File: doc/ex_flag_stage.md
Name: ex_flag_stage

Overview:
- EX/MEM boundary stage directly downstream of the 16-bit ALU.
- Registers the ALU result and destination info toward the MEM stage.
- Owns the architectural Z/N/V flag register, applying a per-operation flag-update mask.
- Evaluates branch conditions against the committed flags.
- Supports pipeline stall and flush from the hazard unit.

Parameters:
- DW, 16: datapath width of the ALU result.
- RW, 4: register-file index width for the destination register.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  synchronous, active-high reset.
- ex_valid  in  1  the EX-stage instruction is real, not a bubble.
- ex_alu_ctrl  in  4  ALU control code of the EX instruction; same encoding the ALU consumes.
- ex_result  in  DW  ALU result.
- ex_z  in  1  ALU zero flag.
- ex_n  in  1  ALU negative flag.
- ex_v  in  1  ALU overflow flag.
- ex_dst  in  RW  destination register index.
- ex_wr_en  in  1  the EX instruction writes the register file.
- stall  in  1  hold this stage.
- flush  in  1  kill the EX instruction.
- mem_valid  out  1  registered valid toward MEM.
- mem_result  out  DW  registered ALU result.
- mem_dst  out  RW  registered destination index.
- mem_wr_en  out  1  registered write enable; forced 0 when mem_valid is 0.
- flag_z  out  1  committed Z flag.
- flag_n  out  1  committed N flag.
- flag_v  out  1  committed V flag.
- br_cond  in  3  branch condition code from decode.
- br_taken  out  1  combinational branch decision from the committed flags.

Behaviour:
- Reset: on a rising edge with rst=1, all outputs clear to 0: mem_valid, mem_result, mem_dst, mem_wr_en, flag_z, flag_n, flag_v. rst has priority over flush and stall.
- Priority per edge: rst > flush > stall > normal advance.
- Flush: mem_valid<=0 and mem_wr_en<=0. mem_result and mem_dst are don't-care; the implementation holds them. Flags do not update. A flush asserted together with stall still kills the instruction.
- Stall (flush=0): every register holds, including the flags. The EX instruction is not consumed and is re-presented by upstream.
- Normal advance: mem_valid<=ex_valid; mem_result<=ex_result; mem_dst<=ex_dst; mem_wr_en<=ex_valid&ex_wr_en.
- Flag update on normal advance when ex_valid=1, per ex_alu_ctrl:
  - ADD 0000, SUB 0001: update Z, N and V.
  - NAND 0100, XOR 1000, SLL 1001, SRL 1010, SRA 1011: update Z only.
  - LHB 1100, LLB 1101: no flag update.
  - All other codes: no flag update.
- ex_valid=0 never changes the flags.
- Latency: one cycle from EX input to the mem_* and flag outputs.
- New flags are visible on flag_* the cycle after the updating op. Decode owns the flag hazard: it inserts a bubble before a dependent branch. This block does no flag forwarding.
- br_taken is a pure function of br_cond and the registered flags:
  - 000 NE: !Z
  - 001 EQ: Z
  - 010 GT: !Z & !N
  - 011 LT: N
  - 100 GE: Z | !N
  - 101 LE: Z | N
  - 110 OV: V
  - 111 UN: 1
- The flag bits are stored exactly as the ALU produced them; no masking beyond DW bits.

Decomposition:
- Shared package wisc_pkg holds:
  - the ALU op-code localparams (ADD, SUB, NAND, XOR, SLL, SRL, SRA, LHB, LLB);
  - the branch condition codes;
  - DW and RW defaults.
- The ALU and decode import the same package.
- One sub-module: flag_mask_dec. It is combinational and maps ex_alu_ctrl to {upd_z, upd_n, upd_v}; the mask table lives in this one place.
- The pipeline register and the branch evaluator stay inline in ex_flag_stage.

Test Plan:
- Reset: assert rst 2 cycles with ex_valid=1, ADD, ex_v=ex_n=1 -> all outputs 0 after each edge; br_cond=001 gives br_taken=0, br_cond=000 gives br_taken=1.
- ADD overflow: ex_result=0x8000, v=1, n=1, z=0, dst=3, wr_en=1 -> next cycle mem_result=0x8000, mem_dst=3, mem_wr_en=1, flags N=1 V=1 Z=0; br_cond=110 and 011 taken, 010 not taken.
- Z-only mask: after that, XOR with ex_result=0x0000, z=1, n=0, v=0 -> Z=1, N=1, V=1 retained; then LLB with z=0 -> flags unchanged (Z=1).
- Stall: stall=1 for 3 cycles while ex_result changes 0x1111/0x2222/0x3333 with SUB -> mem_* and flags hold their pre-stall values throughout.
- Flush vs stall: flush=1 and stall=1 with SUB, z=1 -> mem_valid=0, mem_wr_en=0, flags unchanged. Then a bubble (ex_valid=0, wr_en=1) -> mem_wr_en=0.
- Reset mid-stream: rst pulsed 1 cycle during a 5-op ADD sequence -> all outputs 0 on that edge; the following op updates normally from the zeroed state.
